// File: rtl/mux2to1_arb_if.sv
// Bundle of the two source streams, the merged output stream and the mux
// select/status lines around the two-source packet arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface mux2to1_arb_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             a_ready;

  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             b_ready;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  logic             sel;
  logic             busy;

  modport slave (
    input  a_valid, a_data, a_last,
    input  b_valid, b_data, b_last,
    input  out_ready,
    output a_ready, b_ready,
    output out_valid, out_data, out_last,
    output sel, busy
  );

  modport master (
    output a_valid, a_data, a_last,
    output b_valid, b_data, b_last,
    output out_ready,
    input  a_ready, b_ready,
    input  out_valid, out_data, out_last,
    input  sel, busy
  );
endinterface

// File: rtl/mux2to1_arb.sv
// Round-robin packet arbiter in front of a 2:1 data mux. One source owns the
// output from its grant until its last beat is accepted; every packet costs
// one IDLE arbitration cycle. sel (1 = A) is registered and only moves when
// leaving IDLE, so it is stable for the whole packet.
module mux2to1_arb #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  mux2to1_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             prio_q, prio_d;   // 1 = A wins a tie

  logic             out_valid_c;
  logic [WIDTH-1:0] out_data_c;
  logic             out_last_c;
  logic             a_ready_c;
  logic             b_ready_c;

  // State, select and priority registers; reset truncates any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, so ordering inside this block cannot matter.
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

  // Arbitration, packet tracking and combinational steering of the granted source.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    sel_d       = sel_q;
    prio_d      = prio_q;
    out_valid_c = 1'b0;
    out_data_c  = '0;
    out_last_c  = 1'b0;
    a_ready_c   = 1'b0;
    b_ready_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.a_valid && (!bus.b_valid || prio_q)) begin
          state_d = GRANT_A;
          sel_d   = 1'b1;
        end else if (bus.b_valid) begin
          state_d = GRANT_B;
          sel_d   = 1'b0;
        end
      end

      GRANT_A: begin
        out_valid_c = bus.a_valid;
        out_data_c  = bus.a_data;
        out_last_c  = bus.a_last;
        a_ready_c   = bus.out_ready;
        // A stalled source keeps the grant; only an accepted last beat releases it.
        if (bus.a_valid && bus.out_ready && bus.a_last) begin
          state_d = IDLE;
          prio_d  = 1'b0;
        end
      end

      GRANT_B: begin
        out_valid_c = bus.b_valid;
        out_data_c  = bus.b_data;
        out_last_c  = bus.b_last;
        b_ready_c   = bus.out_ready;
        if (bus.b_valid && bus.out_ready && bus.b_last) begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_last  = out_last_c;
  assign bus.a_ready   = a_ready_c;
  assign bus.b_ready   = b_ready_c;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/mux2to1_arb.md
# mux2to1_arb

Two-source packet arbiter that sits directly upstream of the 2:1 data-flow mux and generates its select. It accepts valid/ready packet streams on sources A and B and grants one source at a time, round-robin, holding the grant until the granted packet's last beat is accepted. The registered `sel` output drives the mux select (1 = A, 0 = B), and the arbiter steers the selected stream to a single output port.

## Interface
- `WIDTH`, default 8: data width of each source and of the output stream.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `a_valid`, input, 1: source A beat valid.
- `a_data`, input, WIDTH: source A beat data.
- `a_last`, input, 1: source A beat is the final beat of its packet.
- `a_ready`, output, 1: source A beat accepted this cycle when `a_valid` is also high.
- `b_valid`, `b_data`, `b_last`, `b_ready`: same as the A signals, for source B.
- `out_valid`, output, 1: output beat valid.
- `out_data`, output, WIDTH: output beat data.
- `out_last`, output, 1: output beat ends the packet.
- `out_ready`, input, 1: downstream accepts the output beat.
- `sel`, output, 1: registered mux select; 1 = A granted or last granted, 0 = B.
- `busy`, output, 1: high while in GRANT_A or GRANT_B.

## Operation
- States: IDLE, GRANT_A, GRANT_B. Internal 1-bit `prio` (1 = A preferred).
- **Reset values:** state = IDLE, `sel` = 0, `prio` = 1, `busy` = 0. All combinational outputs follow from these values: `out_valid` = 0, `a_ready` = `b_ready` = 0.
- **IDLE:**
  - `out_valid`, `a_ready`, `b_ready` are all 0.
  - No beat is transferred.
  - Arbitration:
    - Only `a_valid` high: go to GRANT_A and set `sel` = 1.
    - Only `b_valid` high: go to GRANT_B and set `sel` = 0.
    - Both high: grant A if `prio` = 1, otherwise B.
    - Neither high: stay in IDLE and hold `sel`.
- **GRANT_A:**
  - `out_valid` = `a_valid`, `out_data` = `a_data`, `out_last` = `a_last`.
  - `a_ready` = `out_ready`, `b_ready` = 0.
  - A beat transfers when `a_valid` and `out_ready` are both high.
  - When the transferred beat has `a_last` high: go to IDLE and set `prio` = 0.
  - `sel` holds at 1.
- **GRANT_B:** symmetric to GRANT_A. On the last beat, go to IDLE and set `prio` = 1; `sel` holds at 0.
- The output path is combinational from the granted source. Only `sel`, the state and `prio` are registered.
- The non-granted source is never given ready, whatever its `valid` does. Its beats are held by that source.
- `prio` updates only on packet completion. A lone requester does not change priority until its packet ends.
- A granted source deasserting `valid` mid-packet keeps the grant: the state waits indefinitely for more beats.
- **Reset mid-packet:**
  - Immediate return to the reset values, even in the middle of a packet.
  - The in-flight packet is truncated. There is no recovery and no flush.
- `out_ready` high in IDLE has no effect.

## Timing
- Arbitration costs one IDLE cycle per packet. The first beat of a granted packet can transfer in the cycle after the grant decision.
- Each packet occupies at least 2 cycles: 1 IDLE plus N beat cycles.
- Peak throughput with continuous requests and `out_ready` held high, packet length N: N beats per N+1 cycles.
- `sel` changes only on the clock edge leaving IDLE. It is stable throughout a packet.
- Asynchronous reset takes effect without a clock edge. Release is synchronous to `clk`.

## Test plan
- **Reset:** assert `rst_n` = 0 with random inputs -> `sel` = 0, `busy` = 0, `out_valid` = 0, `a_ready` = `b_ready` = 0, with no clock edge needed.
- **A only, 3-beat packet** (0x11, 0x22, 0x33 with last on 0x33), `out_ready` = 1:
  - 1 IDLE cycle, then `sel` = 1 and three consecutive output beats 0x11, 0x22, 0x33.
  - `out_last` high only on 0x33, then back to IDLE.
- **Both sources valid from reset**, A packet 2 beats (0xA0, 0xA1), B packet 1 beat (0xB0):
  - A is granted first, then IDLE, then B.
  - Output order 0xA0, 0xA1, 0xB0.
  - `sel` sequence 1 then 0.
- **Backpressure:** during GRANT_A, hold `out_ready` = 0 for 4 cycles -> `a_ready` = 0, `out_data` stable, no beat lost or duplicated after `out_ready` returns to 1.
- **Fairness:** both sources continuously send 1-beat packets -> grants alternate A, B, A, B, each separated by one IDLE cycle. `b_ready` is never high while `sel` = 1.
- **Reset mid-packet:** assert `rst_n` = 0 after beat 1 of a 3-beat A packet, then release with only `b_valid` high -> the next grant is B (`sel` = 0), and no A beat appears at the output.
